// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, funct codes, ALU op enum and MMIO offsets for the riscv_block tile.
package riscv_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [31:0] MMIO_A11   = 32'h00;
    localparam logic [31:0] MMIO_A12   = 32'h04;
    localparam logic [31:0] MMIO_A21   = 32'h08;
    localparam logic [31:0] MMIO_A22   = 32'h0C;
    localparam logic [31:0] MMIO_B11   = 32'h10;
    localparam logic [31:0] MMIO_B12   = 32'h14;
    localparam logic [31:0] MMIO_B21   = 32'h18;
    localparam logic [31:0] MMIO_B22   = 32'h1C;
    localparam logic [31:0] MMIO_RELU  = 32'h20;
    localparam logic [31:0] MMIO_P00   = 32'h30;
    localparam logic [31:0] MMIO_P01   = 32'h34;
    localparam logic [31:0] MMIO_P10   = 32'h38;
    localparam logic [31:0] MMIO_P11   = 32'h3C;
    localparam logic [31:0] MMIO_CYCLE = 32'h40;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
    } aluOp_e;

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic aluOp_e aluSel(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/riscv_alu.sv
// riscv_alu: combinational RV32I+MUL ALU with branch comparison.
module riscv_alu
    import riscv_pkg::*;
(
    input  aluOp_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  cmpF3,
    output logic [31:0] y,
    output logic        taken
);
    logic eq, lt, ltu;

    assign eq  = a == b;
    assign lt  = $signed(a) < $signed(b);
    assign ltu = a < b;

    always_comb begin
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'b0, lt};
            ALU_SLTU: y = {31'b0, ltu};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_MUL:  y = a * b;
            default:  y = '0;
        endcase
    end

    // funct3[2:1] picks the comparison, funct3[0] inverts it
    assign taken = cmpF3[2:1] == 2'b00 ? eq  ^ cmpF3[0] :
                   cmpF3[2:1] == 2'b10 ? lt  ^ cmpF3[0] :
                   cmpF3[2:1] == 2'b11 ? ltu ^ cmpF3[0] : 1'b0;
endmodule

// File: rtl/riscv_block.sv
// riscv_block: single-cycle RV32I+MUL core with internal memories and a 2x2 matrix MMIO window.
module riscv_block
    import riscv_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] MMIO_BASE  = 32'h1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  matrixA_11,
    input  logic [7:0]  matrixA_12,
    input  logic [7:0]  matrixA_21,
    input  logic [7:0]  matrixA_22,
    input  logic [7:0]  matrixB_11,
    input  logic [7:0]  matrixB_12,
    input  logic [7:0]  matrixB_21,
    input  logic [7:0]  matrixB_22,
    input  logic        ReLU,
    output logic [31:0] matrixp00,
    output logic [31:0] matrixp01,
    output logic [31:0] matrixp10,
    output logic [31:0] matrixp11,
    output logic [31:0] cycle_count
);
    localparam int          IA      = $clog2(IMEM_DEPTH);
    localparam int          DA      = $clog2(DMEM_DEPTH);
    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);
    localparam logic [31:0] DMEM_END = 32'(DMEM_DEPTH * 4);

    logic [31:0] instr_mem [IMEM_DEPTH];
    logic [31:0] data_mem  [DMEM_DEPTH];
    logic [31:0] regs      [32];

    logic [31:0] pc, instr, rv1, rv2, immI, immS, immB, immU, immJ;
    logic [31:0] aluB, aluY, addr, wordAddr, loadData, wbData, nextPc, pcPlus4, resVal;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        taken, isStore, inDmem, regWe;
    aluOp_e      aluOp;

    assign instr  = instr_mem[pc[IA+1:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign immI = {{20{instr[31]}}, instr[31:20]};
    assign immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign immU = {instr[31:12], 12'b0};
    assign immJ = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rv1 = regs[rs1];
    assign rv2 = regs[rs2];

    assign aluOp = (opcode == OP_REG && funct7 == F7_MULDIV) ? ALU_MUL :
                   aluSel(funct3, opcode == OP_REG ? instr[30] : (funct3 == F3_SR && instr[30]));
    assign aluB  = (opcode == OP_REG || opcode == OP_BRANCH) ? rv2 : immI;

    riscv_alu alu (
        .op    (aluOp),
        .a     (rv1),
        .b     (aluB),
        .cmpF3 (funct3),
        .y     (aluY),
        .taken (taken)
    );

    assign isStore  = opcode == OP_STORE;
    assign addr     = rv1 + (isStore ? immS : immI);
    assign wordAddr = addr & ~32'd3;
    assign inDmem   = wordAddr < DMEM_END;
    assign resVal   = (ReLU && rv2[31]) ? '0 : rv2;

    always_comb begin
        loadData = '0;
        if (inDmem)
            loadData = data_mem[wordAddr[DA+1:2]];
        else
            case (wordAddr)
                MMIO_BASE + MMIO_A11:   loadData = {24'b0, matrixA_11};
                MMIO_BASE + MMIO_A12:   loadData = {24'b0, matrixA_12};
                MMIO_BASE + MMIO_A21:   loadData = {24'b0, matrixA_21};
                MMIO_BASE + MMIO_A22:   loadData = {24'b0, matrixA_22};
                MMIO_BASE + MMIO_B11:   loadData = {24'b0, matrixB_11};
                MMIO_BASE + MMIO_B12:   loadData = {24'b0, matrixB_12};
                MMIO_BASE + MMIO_B21:   loadData = {24'b0, matrixB_21};
                MMIO_BASE + MMIO_B22:   loadData = {24'b0, matrixB_22};
                MMIO_BASE + MMIO_RELU:  loadData = {31'b0, ReLU};
                MMIO_BASE + MMIO_P00:   loadData = matrixp00;
                MMIO_BASE + MMIO_P01:   loadData = matrixp01;
                MMIO_BASE + MMIO_P10:   loadData = matrixp10;
                MMIO_BASE + MMIO_P11:   loadData = matrixp11;
                MMIO_BASE + MMIO_CYCLE: loadData = cycle_count;
                default:                loadData = '0;
            endcase
    end

    assign pcPlus4 = pc + 32'd4;
    assign nextPc  = opcode == OP_JAL                ? pc + immJ :
                     opcode == OP_JALR               ? (rv1 + immI) & ~32'd1 :
                     (opcode == OP_BRANCH && taken)  ? pc + immB : pcPlus4;
    assign wbData  = opcode == OP_LUI                          ? immU :
                     opcode == OP_AUIPC                        ? pc + immU :
                     (opcode == OP_JAL || opcode == OP_JALR)   ? pcPlus4 :
                     opcode == OP_LOAD                         ? loadData : aluY;
    assign regWe   = rd != 5'd0 && (opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL ||
                     opcode == OP_JALR || opcode == OP_LOAD || opcode == OP_IMM || opcode == OP_REG);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc          <= '0;
            cycle_count <= '0;
            matrixp00   <= '0;
            matrixp01   <= '0;
            matrixp10   <= '0;
            matrixp11   <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            pc          <= nextPc & PC_MASK;
            cycle_count <= cycle_count + 32'd1;
            if (regWe) regs[rd] <= wbData;
            if (isStore && wordAddr == MMIO_BASE + MMIO_P00) matrixp00 <= resVal;
            if (isStore && wordAddr == MMIO_BASE + MMIO_P01) matrixp01 <= resVal;
            if (isStore && wordAddr == MMIO_BASE + MMIO_P10) matrixp10 <= resVal;
            if (isStore && wordAddr == MMIO_BASE + MMIO_P11) matrixp11 <= resVal;
        end
    end

    // data memory has no reset so software-visible contents survive a core restart
    always_ff @(posedge clk) begin
        if (!rst_n && isStore && inDmem) data_mem[wordAddr[DA+1:2]] <= rv2;
    end
endmodule

// File: tb/tb_riscv_block.sv
// tb_riscv_block: directed firmware tests for riscv_block with hand-computed expectations.
module tb_riscv_block;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  matrixA_11, matrixA_12, matrixA_21, matrixA_22;
    logic [7:0]  matrixB_11, matrixB_12, matrixB_21, matrixB_22;
    logic        ReLU;
    logic [31:0] matrixp00, matrixp01, matrixp10, matrixp11, cycle_count;

    int passCnt = 0;
    int failCnt = 0;
    int total   = 0;
    logic [31:0] prog [$];

    riscv_block dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .matrixA_11  (matrixA_11),
        .matrixA_12  (matrixA_12),
        .matrixA_21  (matrixA_21),
        .matrixA_22  (matrixA_22),
        .matrixB_11  (matrixB_11),
        .matrixB_12  (matrixB_12),
        .matrixB_21  (matrixB_21),
        .matrixB_22  (matrixB_22),
        .ReLU        (ReLU),
        .matrixp00   (matrixp00),
        .matrixp01   (matrixp01),
        .matrixp10   (matrixp10),
        .matrixp11   (matrixp11),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] iT(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] rT(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm); return iT(imm, rs1, 0, rd, 'h13); endfunction
    function automatic logic [31:0] lw(int rd, int rs1, int imm);   return iT(imm, rs1, 2, rd, 'h03); endfunction
    function automatic logic [31:0] add(int rd, int a, int b);      return rT(0, b, a, 0, rd);        endfunction
    function automatic logic [31:0] mul(int rd, int a, int b);      return rT(1, b, a, 0, rd);        endfunction
    function automatic logic [31:0] sw(int rs2, int rs1, int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] bne(int rs1, int rs2, int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b001, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] lui(int rd, int imm20);
        return {imm20[19:0], rd[4:0], 7'h37};
    endfunction
    function automatic logic [31:0] jal(int rd, int imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    task automatic emit(input logic [31:0] w);
        prog.push_back(w);
    endtask

    task automatic loadProg();
        for (int i = 0; i < 256; i++) dut.instr_mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
        prog.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setMats(input int a11, a12, a21, a22, b11, b12, b21, b22);
        matrixA_11 = a11[7:0]; matrixA_12 = a12[7:0]; matrixA_21 = a21[7:0]; matrixA_22 = a22[7:0];
        matrixB_11 = b11[7:0]; matrixB_12 = b12[7:0]; matrixB_21 = b21[7:0]; matrixB_22 = b22[7:0];
    endtask

    initial begin
        rst_n = 1'b1;
        ReLU  = 1'b0;
        setMats(0, 0, 0, 0, 0, 0, 0, 0);

        // ISA directed program; fail path writes 0x3FF to p10
        emit(lui(5, 1));         emit(addi(1, 0, -1));    emit(sw(1, 0, 16));      emit(lw(2, 0, 16));
        emit(bne(1, 2, 56));     emit(sw(1, 5, 'h30));    emit(sw(1, 5, 'h34));    emit(addi(3, 0, 255));
        emit(mul(4, 3, 3));      emit(sw(4, 5, 'h3C));    emit(addi(6, 0, 7));     emit(lw(6, 5, 'h24));
        emit(addi(0, 0, 5));     emit(sw(6, 5, 'h30));    emit(sw(0, 5, 'h34));    emit(addi(7, 0, 'h123));
        emit(sw(7, 5, 'h38));    emit(jal(0, 0));         emit(addi(7, 0, 'h3FF)); emit(sw(7, 5, 'h38));
        emit(jal(0, 0));
        loadProg();
        step(3);
        check("rst_p00", matrixp00, 32'h0);
        check("rst_p01", matrixp01, 32'h0);
        check("rst_p10", matrixp10, 32'h0);
        check("rst_p11", matrixp11, 32'h0);
        check("rst_cycles", cycle_count, 32'h0);
        rst_n = 1'b0;
        step(10);
        check("cycles_after_10", cycle_count, 32'd10);
        step(40);
        check("isa_unmapped_lw_p00", matrixp00, 32'h0);
        check("isa_x0_p01", matrixp01, 32'h0);
        check("isa_branch_p10", matrixp10, 32'h123);
        check("isa_mul_p11", matrixp11, 32'hFE01);
        check("isa_dmem4", dut.data_mem[4], 32'hFFFF_FFFF);

        // matmul firmware: loop at byte 4, period 25 instructions
        rst_n = 1'b1;
        emit(lui(5, 1));
        emit(lw(10, 5, 'h00)); emit(lw(11, 5, 'h04)); emit(lw(12, 5, 'h08)); emit(lw(13, 5, 'h0C));
        emit(lw(14, 5, 'h10)); emit(lw(15, 5, 'h14)); emit(lw(16, 5, 'h18)); emit(lw(17, 5, 'h1C));
        emit(mul(20, 10, 14)); emit(mul(21, 11, 16)); emit(add(20, 20, 21)); emit(sw(20, 5, 'h30));
        emit(mul(20, 10, 15)); emit(mul(21, 11, 17)); emit(add(20, 20, 21)); emit(sw(20, 5, 'h34));
        emit(mul(20, 12, 14)); emit(mul(21, 13, 16)); emit(add(20, 20, 21)); emit(sw(20, 5, 'h38));
        emit(mul(20, 12, 15)); emit(mul(21, 13, 17)); emit(add(20, 20, 21)); emit(sw(20, 5, 'h3C));
        emit(jal(0, -96));
        loadProg();
        ReLU = 1'b1;
        setMats(1, 2, 3, 4, 1, 2, 3, 4);
        step(2);
        check("rst2_p11", matrixp11, 32'h0);
        check("rst2_p10", matrixp10, 32'h0);
        rst_n = 1'b0;
        step(30);
        check("mm1_p00", matrixp00, 32'h7);
        check("mm1_p01", matrixp01, 32'hA);
        check("mm1_p10", matrixp10, 32'hF);
        check("mm1_p11", matrixp11, 32'h16);
        setMats(11, 12, 13, 14, 21, 22, 23, 24);
        step(50);
        check("mm2_p00", matrixp00, 32'd507);
        check("mm2_p01", matrixp01, 32'd530);
        check("mm2_p10", matrixp10, 32'd595);
        check("mm2_p11", matrixp11, 32'd622);
        check("mm2_cycles", cycle_count, 32'd80);
        step(7);
        rst_n = 1'b1;
        step(1);
        check("midrst_p00", matrixp00, 32'h0);
        check("midrst_p11", matrixp11, 32'h0);
        check("midrst_cycles", cycle_count, 32'h0);
        rst_n = 1'b0;
        step(30);
        check("reconv_p00", matrixp00, 32'd507);
        check("reconv_p01", matrixp01, 32'd530);
        check("reconv_p10", matrixp10, 32'd595);
        check("reconv_p11", matrixp11, 32'd622);
        check("reconv_cycles", cycle_count, 32'd30);

        // ReLU program: store -5 to p00 and the ReLU flag to p01 in a 4-instruction loop
        rst_n = 1'b1;
        emit(lui(5, 1));      emit(addi(1, 0, -5));   emit(sw(1, 5, 'h30));
        emit(lw(2, 5, 'h20)); emit(sw(2, 5, 'h34));   emit(jal(0, -12));
        loadProg();
        ReLU = 1'b1;
        step(2);
        rst_n = 1'b0;
        step(10);
        check("relu1_p00", matrixp00, 32'h0);
        check("relu1_flag_p01", matrixp01, 32'h1);
        ReLU = 1'b0;
        step(5);
        check("relu0_p00", matrixp00, 32'hFFFF_FFFB);
        check("relu0_flag_p01", matrixp01, 32'h0);
        ReLU = 1'b1;
        step(5);
        check("relu1b_p00", matrixp00, 32'h0);

        $display("%0d/%0d checks passed", passCnt, total);
        $finish;
    end
endmodule
